// File: rtl/types_pkg.sv
// Shared types for the instruction/data memory arbiter.
package types_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_REQ,
      ARB_WAIT
   } arb_state_t;

   typedef enum logic {
      OWN_INSTR,
      OWN_DATA
   } arb_owner_t;

   localparam int MEM_ADDR_W = 32;
   localparam int MEM_DATA_W = 32;

   // Shared-port request as seen by the memory at the default 32-bit widths.
   typedef struct packed {
      logic                      we;
      logic [MEM_DATA_W/8-1:0]   be;
      logic [MEM_ADDR_W-1:0]     addr;
      logic [MEM_DATA_W-1:0]     wdata;
   } mem_req_t;

endpackage

// File: rtl/arb_select.sv
// Winner selection between instruction and data ports.
// MEM_ARB_RR_EN selects round-robin; otherwise data priority with an instruction starvation guard.
module arb_select #(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_req,
   input  logic d_req,
   input  logic update,
   output logic win_data
);

`ifdef MEM_ARB_RR_EN
   // rr_ptr names the port that has priority next: 0 = instruction, 1 = data.
   logic rr_ptr;

   always_comb begin
      win_data = d_req & (~i_req | rr_ptr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= 1'b0;
      end else if (update) begin
         rr_ptr <= ~win_data;
      end
   end
`else
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0] starve_cnt;

   always_comb begin
      win_data = d_req & (~i_req | (starve_cnt < STARVE_LIM));
   end

   // Counter cannot exceed STARVE_LIM: at the limit the instruction port wins and clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= 4'd0;
      end else if (update) begin
         if (!win_data) begin
            starve_cnt <= 4'd0;
         end else if (i_req) begin
            starve_cnt <= starve_cnt + 4'd1;
         end
      end
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the core's fetch and load/store ports, one transaction in flight.
// Arbitration policy is selected by MEM_ARB_RR_EN (round-robin) or left as fixed data priority.
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_gnt,
   output logic                i_rvalid,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [DATA_W/8-1:0] d_be,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                m_req,
   output logic                m_we,
   output logic [DATA_W/8-1:0] m_be,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   input  logic                m_gnt,
   input  logic                m_rvalid,
   input  logic [DATA_W-1:0]   m_rdata
);
   import types_pkg::*;

   localparam int BE_W = DATA_W / 8;

   typedef struct packed {
      logic              we;
      logic [BE_W-1:0]   be;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   arb_state_t state;
   arb_owner_t owner;
   req_t       req_q;
   logic       win_data;
   logic       arb_go;
   logic       gnt_now;
   logic       resp_now;

   assign arb_go = (state == ARB_IDLE) & (i_req | d_req);

   arb_select #(
      .STARVE_MAX(STARVE_MAX)
   ) u_sel (
      .clk      (clk),
      .rst      (rst),
      .i_req    (i_req),
      .d_req    (d_req),
      .update   (arb_go),
      .win_data (win_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ARB_IDLE;
         owner <= OWN_INSTR;
         m_req <= 1'b0;
         req_q <= '0;
      end else begin
         unique case (state)
            ARB_IDLE: begin
               if (arb_go) begin
                  state <= ARB_REQ;
                  m_req <= 1'b1;
                  if (win_data) begin
                     owner       <= OWN_DATA;
                     req_q.we    <= d_we;
                     req_q.be    <= d_be;
                     req_q.addr  <= d_addr;
                     req_q.wdata <= d_wdata;
                  end else begin
                     // Fetches are full-word reads.
                     owner       <= OWN_INSTR;
                     req_q.we    <= 1'b0;
                     req_q.be    <= '1;
                     req_q.addr  <= i_addr;
                     req_q.wdata <= '0;
                  end
               end
            end
            ARB_REQ: begin
               if (m_gnt) begin
                  m_req <= 1'b0;
                  state <= m_rvalid ? ARB_IDLE : ARB_WAIT;
               end
            end
            ARB_WAIT: begin
               if (m_rvalid) begin
                  state <= ARB_IDLE;
               end
            end
            default: begin
               state <= ARB_IDLE;
               m_req <= 1'b0;
            end
         endcase
      end
   end

   // Responses arriving while idle belong to no transaction and are dropped.
   assign gnt_now  = (state == ARB_REQ) & m_gnt;
   assign resp_now = m_rvalid & (gnt_now | (state == ARB_WAIT));

   assign i_gnt    = gnt_now  & (owner == OWN_INSTR);
   assign d_gnt    = gnt_now  & (owner == OWN_DATA);
   assign i_rvalid = resp_now & (owner == OWN_INSTR);
   assign d_rvalid = resp_now & (owner == OWN_DATA);
   assign i_rdata  = m_rdata;
   assign d_rdata  = m_rdata;

   assign m_we    = req_q.we;
   assign m_be    = req_q.be;
   assign m_addr  = req_q.addr;
   assign m_wdata = req_q.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; the round-robin section builds when MEM_ARB_RR_EN is defined.
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [3:0]  d_be;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        m_req;
   logic        m_we;
   logic [3:0]  m_be;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_gnt;
   logic        m_rvalid;
   logic [31:0] m_rdata;

   int n_chk;
   int n_pass;

   mem_arbiter #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .STARVE_MAX (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .i_req    (i_req),
      .i_addr   (i_addr),
      .i_gnt    (i_gnt),
      .i_rvalid (i_rvalid),
      .i_rdata  (i_rdata),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_be     (d_be),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_gnt    (d_gnt),
      .d_rvalid (d_rvalid),
      .d_rdata  (d_rdata),
      .m_req    (m_req),
      .m_we     (m_we),
      .m_be     (m_be),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_gnt    (m_gnt),
      .m_rvalid (m_rvalid),
      .m_rdata  (m_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Ticks until m_req is seen, bounded; returns how many ticks it took.
   task automatic wait_mreq(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!m_req && n < 8);
      chk("mreq_timeout", {63'd0, m_req}, 64'd1);
   endtask

   int nw;

   initial begin
      n_chk    = 0;
      n_pass   = 0;
      rst      = 1'b1;
      i_req    = 1'b0;
      i_addr   = 32'h0;
      d_req    = 1'b0;
      d_we     = 1'b0;
      d_be     = 4'h0;
      d_addr   = 32'h0;
      d_wdata  = 32'h0;
      m_gnt    = 1'b0;
      m_rvalid = 1'b0;
      m_rdata  = 32'h0;

      // Reset state
      tick();
      tick();
      chk("rst_m_req",    m_req,    0);
      chk("rst_m_addr",   m_addr,   0);
      chk("rst_m_be",     m_be,     0);
      chk("rst_m_we",     m_we,     0);
      chk("rst_gnts",     {i_gnt, d_gnt}, 0);
      chk("rst_rvalids",  {i_rvalid, d_rvalid}, 0);
      rst = 1'b0;

      // Lone fetch, memory grants at once, data two cycles after the grant
      i_req  = 1'b1;
      i_addr = 32'h100;
      #1;
      chk("lf_mreq_t0", m_req, 0);
      tick();
      chk("lf_mreq_t1", m_req, 1);
      chk("lf_maddr",   m_addr, 32'h100);
      chk("lf_mwe",     m_we, 0);
      m_gnt = 1'b1;
      #1;
      chk("lf_gnts",    {i_gnt, d_gnt}, 2'b10);
      tick();
      i_req = 1'b0;
      m_gnt = 1'b0;
      #1;
      chk("lf_wait_mreq", m_req, 0);
      chk("lf_wait_gnt",  i_gnt, 0);
      tick();
      chk("lf_no_early_rv", i_rvalid, 0);
      tick();
      m_rvalid = 1'b1;
      m_rdata  = 32'hDEADBEEF;
      #1;
      chk("lf_rvalids", {i_rvalid, d_rvalid}, 2'b10);
      chk("lf_rdata",   i_rdata, 32'hDEADBEEF);
      tick();
      m_rvalid = 1'b0;
      #1;
      chk("lf_rv_done", {i_rvalid, d_rvalid}, 0);

      // Reset while a load waits for its response
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_be   = 4'hF;
      d_addr = 32'h300;
      tick();
      chk("rw_maddr", m_addr, 32'h300);
      m_gnt = 1'b1;
      #1;
      chk("rw_dgnt", {i_gnt, d_gnt}, 2'b01);
      tick();
      d_req = 1'b0;
      m_gnt = 1'b0;
      rst   = 1'b1;
      #1;
      chk("rw_rst_mreq",  m_req,  0);
      chk("rw_rst_maddr", m_addr, 0);
      chk("rw_rst_mbe",   m_be,   0);
      tick();
      rst      = 1'b0;
      m_rvalid = 1'b1;
      m_rdata  = 32'h1234;
      #1;
      chk("rw_no_rvalid", {i_rvalid, d_rvalid}, 0);
      tick();
      m_rvalid = 1'b0;
      #1;
      chk("rw_idle_mreq", m_req, 0);

`ifdef MEM_ARB_RR_EN
      // Both ports request continuously against a zero-latency memory
      i_req    = 1'b1;
      i_addr   = 32'h500;
      d_req    = 1'b1;
      d_addr   = 32'h600;
      m_gnt    = 1'b1;
      m_rvalid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         wait_mreq(nw);
         chk($sformatf("rr_gnt%0d", k), {i_gnt, d_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
         chk($sformatf("rr_addr%0d", k), m_addr, (k % 2 == 0) ? 32'h500 : 32'h600);
      end
      i_req    = 1'b0;
      d_req    = 1'b0;
      m_gnt    = 1'b0;
      m_rvalid = 1'b0;
      tick();
      tick();
`else
      // Simultaneous fetch and store: data first, fetch in the next arbitration
      i_req   = 1'b1;
      i_addr  = 32'h104;
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_be    = 4'hF;
      d_addr  = 32'h200;
      d_wdata = 32'h55;
      tick();
      chk("sim_maddr",  m_addr,  32'h200);
      chk("sim_mwe",    m_we,    1);
      chk("sim_mwdata", m_wdata, 32'h55);
      chk("sim_mbe",    m_be,    4'hF);
      m_gnt = 1'b1;
      #1;
      chk("sim_dgnt", {i_gnt, d_gnt}, 2'b01);
      tick();
      d_req = 1'b0;
      d_we  = 1'b0;
      m_gnt = 1'b0;
      m_rvalid = 1'b1;
      #1;
      chk("sim_dack", {i_rvalid, d_rvalid}, 2'b01);
      tick();
      m_rvalid = 1'b0;
      tick();
      chk("sim_i_maddr", m_addr, 32'h104);
      chk("sim_i_mwe",   m_we,   0);
      chk("sim_i_mbe",   m_be,   4'hF);
      m_gnt    = 1'b1;
      m_rvalid = 1'b1;
      m_rdata  = 32'h0BADF00D;
      #1;
      chk("sim_ignt", {i_gnt, d_gnt}, 2'b10);
      chk("sim_irv",  {i_rvalid, d_rvalid}, 2'b10);
      chk("sim_irdata", i_rdata, 32'h0BADF00D);
      tick();
      i_req    = 1'b0;
      m_gnt    = 1'b0;
      m_rvalid = 1'b0;
      tick();

      // Data held continuously: four data wins, one fetch, then the counter starts over
      i_req    = 1'b1;
      i_addr   = 32'h108;
      d_req    = 1'b1;
      d_we     = 1'b0;
      d_addr   = 32'h400;
      m_gnt    = 1'b1;
      m_rvalid = 1'b1;
      m_rdata  = 32'hA5A5A5A5;
      for (int k = 0; k < 10; k++) begin
         wait_mreq(nw);
         chk($sformatf("st_lat%0d", k), nw, (k == 0) ? 1 : 2);
         chk($sformatf("st_gnt%0d", k), {i_gnt, d_gnt}, (k == 4 || k == 9) ? 2'b10 : 2'b01);
         chk($sformatf("st_rv%0d", k), {i_rvalid, d_rvalid}, (k == 4 || k == 9) ? 2'b10 : 2'b01);
      end
      chk("st_rdata", d_rdata, 32'hA5A5A5A5);
      i_req    = 1'b0;
      d_req    = 1'b0;
      m_gnt    = 1'b0;
      m_rvalid = 1'b0;
      tick();
      tick();
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
